output_port_arbiter: RTL and testbench

//  Per-output-port wormhole arbiter for the 5-port mesh router. One instance per output direction.

---
 rtl/output_port_arbiter.sv | 96 +++++++++
 tb/tb_output_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin between input FIFOs at packet granularity,
// holding the crossbar select from head flit until the tail flit has transferred.
module output_port_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int PTR_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xfer,
    output logic                 busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     last_q,  last_d;

    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic                 release_pkt;

    // Pop strobe only ever reaches the owner; other requesters cannot leak through.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_xfer
        assign xfer[gi] = grant_q[gi] & req[gi] & out_ready;
    end

    assign grant       = grant_q;
    assign busy        = (state_q == LOCKED);
    assign release_pkt = xfer[owner_q] & tail[owner_q];

    // Scan offsets from far to near so the closest requester after last_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((int'(last_q) + k) % NUM_PORTS);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d           = LOCKED;
                    owner_d           = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= PTR_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: a packet-level owner/pointer model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_output_port_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] tail = '0;
    logic         out_ready = 1'b0;
    logic [N-1:0] grant;
    logic [N-1:0] xfer;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    output_port_arbiter #(.NUM_PORTS(N), .PTR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .xfer      (xfer),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: owner is an input number (-1 when the output is free), last is the previous winner.
    int owner = -1;
    int last  = N - 1;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            owner      = -1;
            last       = N - 1;
            model_live = 1'b1;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (owner < 0 && req[c]) owner = c;
            end
        end else if (req[owner] && out_ready && tail[owner]) begin
            last  = owner;
            owner = -1;
        end
    end

    function automatic logic [N-1:0] exp_grant();
        return (owner < 0) ? '0 : (N'(1) << owner);
    endfunction

    function automatic logic [N-1:0] exp_xfer();
        if (owner >= 0 && req[owner] && out_ready) return N'(1) << owner;
        return '0;
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            n_checks++;
            if (grant !== exp_grant() || xfer !== exp_xfer() || busy !== (owner >= 0)) begin
                n_fail++;
                $display("FAIL model t=%0t grant=%b xfer=%b busy=%b required grant=%b xfer=%b busy=%b",
                         $time, grant, xfer, busy, exp_grant(), exp_xfer(), owner >= 0);
            end
            n_checks++;
            if ($countones(grant) > 1) begin
                n_fail++;
                $display("FAIL onehot t=%0t grant=%b required at most one bit", $time, grant);
            end
        end
    end

    // One cycle: inputs change just after the rising edge, outputs are read at the falling edge.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] t, input logic o,
                       input logic rs = 1'b0);
        @(posedge clk);
        #1;
        rst       = rs;
        req       = r;
        tail      = t;
        out_ready = o;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [N-1:0] g, input logic [N-1:0] x,
                       input logic b);
        n_checks++;
        if (grant !== g || xfer !== x || busy !== b) begin
            n_fail++;
            $display("FAIL %s grant=%b xfer=%b busy=%b required grant=%b xfer=%b busy=%b",
                     name, grant, xfer, busy, g, x, b);
        end else begin
            $display("ok   %s grant=%b xfer=%b busy=%b", name, grant, xfer, busy);
        end
    endtask

    task automatic do_reset();
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b1);
        lit("reset", '0, '0, 1'b0);
    endtask

    logic [N-1:0] rr_seq [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    initial begin
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b1);
        lit("reset_state", '0, '0, 1'b0);

        // Single-flit packet on port 2.
        cyc(5'b00100, 5'b00100, 1'b1);
        lit("t1_req_cycle", '0, '0, 1'b0);
        cyc(5'b00100, 5'b00100, 1'b1);
        lit("t1_grant", 5'b00100, 5'b00100, 1'b1);
        cyc('0, '0, 1'b1);
        lit("t1_release", '0, '0, 1'b0);

        // All ports requesting single-flit packets: strict rotation with an idle gap.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(5'b11111, 5'b11111, 1'b1);
            lit($sformatf("t2_gap%0d", k), '0, '0, 1'b0);
            cyc(5'b11111, 5'b11111, 1'b1);
            lit($sformatf("t2_win%0d", k), rr_seq[k], rr_seq[k], 1'b1);
        end

        // Port 1, 3-flit packet, out_ready 1,0,0,1,1.
        do_reset();
        cyc(5'b00010, '0, 1'b1);
        lit("t3_req", '0, '0, 1'b0);
        cyc(5'b00010, '0, 1'b1);
        lit("t3_f1", 5'b00010, 5'b00010, 1'b1);
        cyc(5'b00010, '0, 1'b0);
        lit("t3_stall1", 5'b00010, '0, 1'b1);
        cyc(5'b00010, '0, 1'b0);
        lit("t3_stall2", 5'b00010, '0, 1'b1);
        cyc(5'b00010, '0, 1'b1);
        lit("t3_f2", 5'b00010, 5'b00010, 1'b1);
        cyc(5'b00010, 5'b00010, 1'b1);
        lit("t3_tail", 5'b00010, 5'b00010, 1'b1);
        cyc('0, '0, 1'b1);
        lit("t3_free", '0, '0, 1'b0);

        // Port 3 waits behind port 1; stray tail on 3 and tail on 1 with out_ready=0 do not release.
        do_reset();
        cyc(5'b00010, '0, 1'b1);
        cyc(5'b01010, 5'b01000, 1'b1);
        lit("t4_owner_only", 5'b00010, 5'b00010, 1'b1);
        cyc(5'b01010, 5'b00010, 1'b0);
        lit("t4_tail_notready", 5'b00010, '0, 1'b1);
        cyc(5'b01010, 5'b00010, 1'b1);
        lit("t4_tail_xfer", 5'b00010, 5'b00010, 1'b1);
        cyc(5'b01000, 5'b01000, 1'b1);
        lit("t4_gap", '0, '0, 1'b0);
        cyc(5'b01000, 5'b01000, 1'b1);
        lit("t4_port3", 5'b01000, 5'b01000, 1'b1);
        cyc('0, '0, 1'b1);

        // Owner (port 0) runs dry for 4 cycles while port 2 asks.
        do_reset();
        cyc(5'b00001, '0, 1'b1);
        cyc(5'b00001, '0, 1'b1);
        lit("t5_head", 5'b00001, 5'b00001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(5'b00100, 5'b00100, 1'b1);
            lit($sformatf("t5_dry%0d", k), 5'b00001, '0, 1'b1);
        end
        cyc(5'b00101, 5'b00001, 1'b1);
        lit("t5_resume_tail", 5'b00001, 5'b00001, 1'b1);
        cyc('0, '0, 1'b1);
        lit("t5_free", '0, '0, 1'b0);

        // Reset mid-packet on port 4 abandons it and restores port-0 priority.
        do_reset();
        cyc(5'b10000, '0, 1'b1);
        cyc(5'b10000, '0, 1'b1);
        lit("t6_locked4", 5'b10000, 5'b10000, 1'b1);
        cyc(5'b10000, '0, 1'b1, 1'b1);
        cyc(5'b10001, '0, 1'b1);
        lit("t6_after_rst", '0, '0, 1'b0);
        cyc(5'b10001, 5'b00001, 1'b1);
        lit("t6_port0", 5'b00001, 5'b00001, 1'b1);
        cyc(5'b10000, 5'b10000, 1'b1);
        lit("t6_gap", '0, '0, 1'b0);
        cyc(5'b10000, 5'b10000, 1'b1);
        lit("t6_port4", 5'b10000, 5'b10000, 1'b1);
        cyc('0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
